// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
//  Module      : branch_rs
//  Description : In-order reservation station for conditional branches.
//                Holds issued branches until both operands are known (either
//                at issue or captured from the CDB) and hands them to the
//                branch unit one per cycle, oldest first.
//  Revision    : 1.0 - initial release
// ============================================================================

package len5_pkg;
    localparam int XLEN  = 64;
    localparam int B_IMM = 12;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd2,
        BGE  = 3'd3,
        BLTU = 3'd4,
        BGEU = 3'd5
    } branch_type_t;
endpackage

module branch_rs
    import len5_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ROB_IDX_LEN = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,

    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  branch_type_t           issue_type_i,
    input  logic                   issue_rs1_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
    input  logic [XLEN-1:0]        issue_rs1_value_i,
    input  logic                   issue_rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
    input  logic [XLEN-1:0]        issue_rs2_value_i,
    input  logic [B_IMM-1:0]       issue_imm_i,
    input  logic [XLEN-1:0]        issue_pc_i,
    input  logic [XLEN-1:0]        issue_pred_target_i,
    input  logic                   issue_pred_taken_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,

    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_idx_i,
    input  logic [XLEN-1:0]        cdb_value_i,

    output logic                   bu_valid_o,
    input  logic                   bu_ready_i,
    output logic [XLEN-1:0]        bu_rs1_o,
    output logic [XLEN-1:0]        bu_rs2_o,
    output logic [B_IMM-1:0]       bu_imm_o,
    output logic [XLEN-1:0]        bu_pc_o,
    output logic [XLEN-1:0]        bu_pred_target_o,
    output logic                   bu_pred_taken_o,
    output branch_type_t           bu_type_o,
    output logic [ROB_IDX_LEN-1:0] bu_rob_idx_o
);

    localparam int                 C_PTR_W   = $clog2(DEPTH);
    localparam int                 C_CNT_W   = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

    typedef struct packed {
        logic                   valid;
        logic                   rs1_rdy;
        logic [ROB_IDX_LEN-1:0] rs1_idx;
        logic [XLEN-1:0]        rs1_value;
        logic                   rs2_rdy;
        logic [ROB_IDX_LEN-1:0] rs2_idx;
        logic [XLEN-1:0]        rs2_value;
        logic [B_IMM-1:0]       imm;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        pred_target;
        logic                   pred_taken;
        branch_type_t           br_type;
        logic [ROB_IDX_LEN-1:0] rob_idx;
    } entry_t;

    entry_t [DEPTH-1:0]  entries_q, entries_d;
    logic [C_PTR_W-1:0]  head_q, head_d;
    logic [C_PTR_W-1:0]  tail_q, tail_d;
    logic [C_CNT_W-1:0]  count_q, count_d;

    entry_t              w_new_entry;
    logic                w_alloc;
    logic                w_dispatch;

    // Handshakes are derived purely from registered state.
    assign issue_ready_o = (count_q != C_FULL);
    assign bu_valid_o    = entries_q[head_q].valid
                         & entries_q[head_q].rs1_rdy
                         & entries_q[head_q].rs2_rdy;
    assign w_alloc       = issue_valid_i & issue_ready_o;
    assign w_dispatch    = bu_valid_o & bu_ready_i;

    assign bu_rs1_o         = entries_q[head_q].rs1_value;
    assign bu_rs2_o         = entries_q[head_q].rs2_value;
    assign bu_imm_o         = entries_q[head_q].imm;
    assign bu_pc_o          = entries_q[head_q].pc;
    assign bu_pred_target_o = entries_q[head_q].pred_target;
    assign bu_pred_taken_o  = entries_q[head_q].pred_taken;
    assign bu_type_o        = entries_q[head_q].br_type;
    assign bu_rob_idx_o     = entries_q[head_q].rob_idx;

    // Build the incoming entry, catching an operand broadcast in the issue cycle.
    always_comb begin
        w_new_entry             = '0;
        w_new_entry.valid       = 1'b1;
        w_new_entry.rs1_rdy     = issue_rs1_ready_i;
        w_new_entry.rs1_idx     = issue_rs1_idx_i;
        w_new_entry.rs1_value   = issue_rs1_value_i;
        w_new_entry.rs2_rdy     = issue_rs2_ready_i;
        w_new_entry.rs2_idx     = issue_rs2_idx_i;
        w_new_entry.rs2_value   = issue_rs2_value_i;
        w_new_entry.imm         = issue_imm_i;
        w_new_entry.pc          = issue_pc_i;
        w_new_entry.pred_target = issue_pred_target_i;
        w_new_entry.pred_taken  = issue_pred_taken_i;
        w_new_entry.br_type     = issue_type_i;
        w_new_entry.rob_idx     = issue_rob_idx_i;
        if (!issue_rs1_ready_i && cdb_valid_i && (cdb_idx_i == issue_rs1_idx_i)) begin
            w_new_entry.rs1_rdy   = 1'b1;
            w_new_entry.rs1_value = cdb_value_i;
        end
        if (!issue_rs2_ready_i && cdb_valid_i && (cdb_idx_i == issue_rs2_idx_i)) begin
            w_new_entry.rs2_rdy   = 1'b1;
            w_new_entry.rs2_value = cdb_value_i;
        end
    end

    // Next-state: CDB wakeup, dispatch, allocate; flush overrides all of them.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (cdb_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].valid && !entries_q[i].rs1_rdy
                    && (entries_q[i].rs1_idx == cdb_idx_i)) begin
                    entries_d[i].rs1_rdy   = 1'b1;
                    entries_d[i].rs1_value = cdb_value_i;
                end
                if (entries_q[i].valid && !entries_q[i].rs2_rdy
                    && (entries_q[i].rs2_idx == cdb_idx_i)) begin
                    entries_d[i].rs2_rdy   = 1'b1;
                    entries_d[i].rs2_value = cdb_value_i;
                end
            end
        end

        // The dispatched head is always valid and the allocated tail never is,
        // so these two writes never target the same slot.
        if (w_dispatch) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + C_PTR_ONE;
        end
        if (w_alloc) begin
            entries_d[tail_q] = w_new_entry;
            tail_d            = tail_q + C_PTR_ONE;
        end

        if (w_alloc && !w_dispatch) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_alloc && w_dispatch) begin
            count_d = count_q - C_CNT_ONE;
        end

        if (flush_i) begin
            entries_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_rs
//  Description : Self-checking bench for branch_rs. A queue-based model of the
//                station predicts the outputs every cycle; directed scenarios
//                are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_rs;
    import len5_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW    = 4;

    logic               clk = 1'b0;
    logic               rst, flush;
    logic               issue_valid, issue_ready;
    branch_type_t       issue_type;
    logic               issue_rs1_ready, issue_rs2_ready;
    logic [RW-1:0]      issue_rs1_idx, issue_rs2_idx;
    logic [XLEN-1:0]    issue_rs1_value, issue_rs2_value;
    logic [B_IMM-1:0]   issue_imm;
    logic [XLEN-1:0]    issue_pc, issue_pred_target;
    logic               issue_pred_taken;
    logic [RW-1:0]      issue_rob_idx;
    logic               cdb_valid;
    logic [RW-1:0]      cdb_idx;
    logic [XLEN-1:0]    cdb_value;
    logic               bu_valid, bu_ready;
    logic [XLEN-1:0]    bu_rs1, bu_rs2, bu_pc, bu_pred_target;
    logic [B_IMM-1:0]   bu_imm;
    logic               bu_pred_taken;
    branch_type_t       bu_type;
    logic [RW-1:0]      bu_rob_idx;

    branch_rs #(.DEPTH(DEPTH), .ROB_IDX_LEN(RW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_type_i(issue_type),
        .issue_rs1_ready_i(issue_rs1_ready), .issue_rs1_idx_i(issue_rs1_idx),
        .issue_rs1_value_i(issue_rs1_value),
        .issue_rs2_ready_i(issue_rs2_ready), .issue_rs2_idx_i(issue_rs2_idx),
        .issue_rs2_value_i(issue_rs2_value),
        .issue_imm_i(issue_imm), .issue_pc_i(issue_pc),
        .issue_pred_target_i(issue_pred_target), .issue_pred_taken_i(issue_pred_taken),
        .issue_rob_idx_i(issue_rob_idx),
        .cdb_valid_i(cdb_valid), .cdb_idx_i(cdb_idx), .cdb_value_i(cdb_value),
        .bu_valid_o(bu_valid), .bu_ready_i(bu_ready),
        .bu_rs1_o(bu_rs1), .bu_rs2_o(bu_rs2), .bu_imm_o(bu_imm), .bu_pc_o(bu_pc),
        .bu_pred_target_o(bu_pred_target), .bu_pred_taken_o(bu_pred_taken),
        .bu_type_o(bu_type), .bu_rob_idx_o(bu_rob_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an ordered list of pending branches
    typedef struct {
        branch_type_t     typ;
        bit               r1;
        logic [RW-1:0]    t1;
        logic [XLEN-1:0]  v1;
        bit               r2;
        logic [RW-1:0]    t2;
        logic [XLEN-1:0]  v2;
        logic [B_IMM-1:0] imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  tgt;
        logic             tk;
        logic [RW-1:0]    rob;
    } ent_t;

    ent_t m_q[$];
    ent_t m_e;
    bit   m_alloc, m_disp;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_q.delete();
        end else begin
            m_alloc = issue_valid && (m_q.size() != DEPTH);
            m_disp  = (m_q.size() != 0) && m_q[0].r1 && m_q[0].r2 && bu_ready;
            if (cdb_valid) begin
                foreach (m_q[i]) begin
                    if (!m_q[i].r1 && m_q[i].t1 == cdb_idx) begin m_q[i].r1 = 1; m_q[i].v1 = cdb_value; end
                    if (!m_q[i].r2 && m_q[i].t2 == cdb_idx) begin m_q[i].r2 = 1; m_q[i].v2 = cdb_value; end
                end
            end
            if (m_disp) void'(m_q.pop_front());
            if (m_alloc) begin
                m_e.typ = issue_type;
                m_e.r1  = issue_rs1_ready; m_e.t1 = issue_rs1_idx; m_e.v1 = issue_rs1_value;
                m_e.r2  = issue_rs2_ready; m_e.t2 = issue_rs2_idx; m_e.v2 = issue_rs2_value;
                if (!m_e.r1 && cdb_valid && cdb_idx == m_e.t1) begin m_e.r1 = 1; m_e.v1 = cdb_value; end
                if (!m_e.r2 && cdb_valid && cdb_idx == m_e.t2) begin m_e.r2 = 1; m_e.v2 = cdb_value; end
                m_e.imm = issue_imm; m_e.pc = issue_pc; m_e.tgt = issue_pred_target;
                m_e.tk  = issue_pred_taken; m_e.rob = issue_rob_idx;
                m_q.push_back(m_e);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit exp_v = (m_q.size() != 0) && m_q[0].r1 && m_q[0].r2;
            chk("issue_ready", 64'(issue_ready), 64'(m_q.size() != DEPTH));
            chk("bu_valid", 64'(bu_valid), 64'(exp_v));
            if (exp_v) begin
                chk("bu_rs1", bu_rs1, m_q[0].v1);
                chk("bu_rs2", bu_rs2, m_q[0].v2);
                chk("bu_imm", 64'(bu_imm), 64'(m_q[0].imm));
                chk("bu_pc", bu_pc, m_q[0].pc);
                chk("bu_pred_target", bu_pred_target, m_q[0].tgt);
                chk("bu_pred_taken", 64'(bu_pred_taken), 64'(m_q[0].tk));
                chk("bu_type", 64'(bu_type), 64'(m_q[0].typ));
                chk("bu_rob_idx", 64'(bu_rob_idx), 64'(m_q[0].rob));
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic set_issue(input branch_type_t t,
                             input bit r1, input logic [RW-1:0] t1, input logic [XLEN-1:0] v1,
                             input bit r2, input logic [RW-1:0] t2, input logic [XLEN-1:0] v2,
                             input logic [XLEN-1:0] pc);
        issue_valid       = 1'b1;
        issue_type        = t;
        issue_rs1_ready   = r1; issue_rs1_idx = t1; issue_rs1_value = v1;
        issue_rs2_ready   = r2; issue_rs2_idx = t2; issue_rs2_value = v2;
        issue_pc          = pc;
        issue_imm         = pc[11:0] ^ 12'h5a5;
        issue_pred_target = pc + 64'h40;
        issue_pred_taken  = pc[2];
        issue_rob_idx     = pc[5:2];
    endtask

    task automatic set_cdb(input logic [RW-1:0] idx, input logic [XLEN-1:0] val);
        cdb_valid = 1'b1;
        cdb_idx   = idx;
        cdb_value = val;
    endtask

    initial begin
        rst = 1'b1; bu_ready = 1'b0;
        idle_strobes();
        set_issue(BEQ, 1, '0, '0, 1, '0, '0, '0);
        issue_valid = 1'b0;
        cdb_idx = '0; cdb_value = '0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("reset issue_ready", 64'(issue_ready), 64'd1);
        chk("reset bu_valid", 64'(bu_valid), 64'd0);
        chk("reset bu_pc", bu_pc, 64'd0);
        chk("reset bu_rs1", bu_rs1, 64'd0);
        chk("reset bu_rob_idx", 64'(bu_rob_idx), 64'd0);

        // 1: ready branch into empty buffer, visible next cycle
        bu_ready = 1'b1;
        set_issue(BEQ, 1, 4'd0, 64'd5, 1, 4'd0, 64'd5, 64'h100);
        tick(); idle_strobes();
        chk("t1 bu_valid", 64'(bu_valid), 64'd1);
        chk("t1 bu_pc", bu_pc, 64'h100);
        tick();
        chk("t1 empty after", 64'(bu_valid), 64'd0);

        // 2: rs1 waits on tag 3, CDB two cycles later
        set_issue(BLT, 0, 4'd3, 64'd0, 1, 4'd0, 64'd7, 64'h200);
        tick(); idle_strobes();
        tick();
        set_cdb(4'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2 waiting", 64'(bu_valid), 64'd0);
        tick(); idle_strobes();
        chk("t2 bu_valid", 64'(bu_valid), 64'd1);
        chk("t2 bu_rs1", bu_rs1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // 3: allocation bypass of rs2
        set_issue(BNE, 1, 4'd0, 64'd1, 0, 4'd7, 64'd0, 64'h280);
        set_cdb(4'd7, 64'd42);
        tick(); idle_strobes();
        chk("t3 bu_valid", 64'(bu_valid), 64'd1);
        chk("t3 bu_rs2", bu_rs2, 64'd42);
        tick();

        // 4: fill (pointers wrap), refused issue on first dispatch cycle, drain in order
        bu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(BGE, 1, 4'd0, 64'(i), 1, 4'd0, 64'(i + 10), 64'h300 + 64'(4 * i));
            tick();
        end
        idle_strobes();
        chk("t4 full", 64'(issue_ready), 64'd0);
        bu_ready = 1'b1;
        set_issue(BGEU, 1, 4'd0, 64'd0, 1, 4'd0, 64'd0, 64'h400);
        chk("t4 head pc", bu_pc, 64'h300);
        tick(); idle_strobes();
        chk("t4 second pc", bu_pc, 64'h304);
        for (int i = 0; i < 3; i++) tick();
        chk("t4 drained", 64'(bu_valid), 64'd0);

        // 5: not-ready head blocks a ready younger entry
        set_issue(BLTU, 0, 4'd2, 64'd0, 1, 4'd0, 64'd3, 64'h500);
        tick();
        set_issue(BEQ, 1, 4'd0, 64'd8, 1, 4'd0, 64'd8, 64'h504);
        tick(); idle_strobes();
        chk("t5 blocked", 64'(bu_valid), 64'd0);
        tick();
        chk("t5 still blocked", 64'(bu_valid), 64'd0);
        set_cdb(4'd2, 64'd9);
        tick(); idle_strobes();
        chk("t5 head pc", bu_pc, 64'h500);
        chk("t5 head rs1", bu_rs1, 64'd9);
        tick();
        chk("t5 younger pc", bu_pc, 64'h504);
        tick();

        // 6: flush with three waiting entries and a concurrent issue
        bu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_issue(BNE, 0, 4'(10 + i), 64'd0, 1, 4'd0, 64'd1, 64'h600 + 64'(4 * i));
            tick();
        end
        set_issue(BEQ, 1, 4'd0, 64'd0, 1, 4'd0, 64'd0, 64'h680);
        flush = 1'b1;
        tick(); idle_strobes();
        chk("t6 ready", 64'(issue_ready), 64'd1);
        chk("t6 valid", 64'(bu_valid), 64'd0);
        set_cdb(4'd10, 64'd1);
        tick(); idle_strobes();
        chk("t6 no wake", 64'(bu_valid), 64'd0);
        bu_ready = 1'b1;
        set_issue(BGE, 1, 4'd0, 64'd2, 1, 4'd0, 64'd3, 64'h700);
        tick(); idle_strobes();
        chk("t6 fresh pc", bu_pc, 64'h700);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle_strobes();
            if ($urandom_range(0, 99) < 60)
                set_issue(branch_type_t'($urandom_range(0, 5)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), {$urandom, $urandom},
                          {32'h0, $urandom});
            if ($urandom_range(0, 99) < 45)
                set_cdb(4'($urandom_range(0, 7)), {$urandom, $urandom});
            bu_ready = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle_strobes();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
